// File: rtl/riscv_mc_ctrl.sv
// riscv_mc_ctrl: multi-cycle RV32I control sequencer (FETCH/DECODE/EXEC/MEM/WB/HALT)
//
// Ports:
//   CLK, RST      rising-edge clock, synchronous active-high reset
//   run           allows a new instruction fetch to start
//   opcode        IR[6:0], valid from DECODE onward
//   br_taken      branch comparison result, valid in EXEC
//   mem_ready     memory port completes the current request this cycle
//   pc_we/pc_src  PC write enable / source (0 = PC+4, 1 = ALU)
//   ir_we         IR and OLDPC capture
//   rf_we/wb_sel  register file write / source (0 ALU, 1 mem, 2 PC link)
//   alu_a_sel     0 rs1, 1 OLDPC, 2 zero
//   alu_b_sel     0 rs2, 1 immediate
//   alu_op        0 add, 1 funct-decoded, 2 branch compare
//   mem_req/mem_we/mem_addr_sel  memory request, store qualifier, address (0 PC, 1 ALU)
//   instr_done    one-cycle retire pulse
//   halt          sticky halt until RST
//   state_dbg     current state encoding
//
// Optional feature macro: RISCV_MC_CTRL_ILLEGAL_TRAP_EN (illegal opcode halts in DECODE;
// otherwise an illegal opcode retires as a NOP).
module riscv_mc_ctrl #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       run,
    input  logic [6:0] opcode,
    input  logic       br_taken,
    input  logic       mem_ready,
    output logic       pc_we,
    output logic       pc_src,
    output logic       ir_we,
    output logic       rf_we,
    output logic [1:0] wb_sel,
    output logic [1:0] alu_a_sel,
    output logic       alu_b_sel,
    output logic [1:0] alu_op,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_addr_sel,
    output logic       instr_done,
    output logic       halt,
    output logic [2:0] state_dbg
);
    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam int WD_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    // The halt decision is taken during the last allowed waiting cycle, so compare
    // against MEM_TIMEOUT-1 completed waiting cycles.
    localparam logic [WD_W-1:0] WD_LIM = WD_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    logic [2:0]      state_q, state_d;
    logic [WD_W-1:0] wd_q, wd_d;
    // Remembers that a fetch request is outstanding, so a later drop of run cannot
    // withdraw it.
    logic            fbusy_q, fbusy_d;

    logic       pc_we_c, pc_src_c, ir_we_c, rf_we_c, alu_b_sel_c;
    logic       mem_req_c, mem_we_c, mem_addr_sel_c, instr_done_c, halt_c;
    logic [1:0] wb_sel_c, alu_a_sel_c, alu_op_c;
    logic       wait_c;

`ifdef RISCV_MC_CTRL_ILLEGAL_TRAP_EN
    function automatic logic is_legal(input logic [6:0] op);
        return op == OPC_OP || op == OPC_OPIMM || op == OPC_LUI || op == OPC_AUIPC ||
               op == OPC_LOAD || op == OPC_STORE || op == OPC_BRANCH || op == OPC_JAL ||
               op == OPC_JALR || op == OPC_FENCE || op == OPC_SYSTEM;
    endfunction
`endif

    always_comb begin
        state_d        = state_q;
        pc_we_c        = 1'b0;
        pc_src_c       = 1'b0;
        ir_we_c        = 1'b0;
        rf_we_c        = 1'b0;
        wb_sel_c       = 2'd0;
        alu_a_sel_c    = 2'd0;
        alu_b_sel_c    = 1'b0;
        alu_op_c       = 2'd0;
        mem_req_c      = 1'b0;
        mem_we_c       = 1'b0;
        mem_addr_sel_c = 1'b0;
        instr_done_c   = 1'b0;
        halt_c         = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (run || fbusy_q) begin
                    mem_req_c = 1'b1;
                    if (mem_ready) begin
                        ir_we_c = 1'b1;
                        pc_we_c = 1'b1;
                        state_d = S_DECODE;
                    end
                end
            end
            S_DECODE: begin
`ifdef RISCV_MC_CTRL_ILLEGAL_TRAP_EN
                state_d = is_legal(opcode) ? S_EXEC : S_HALT;
`else
                state_d = S_EXEC;
`endif
            end
            S_EXEC: begin
                case (opcode)
                    OPC_OP: begin
                        alu_op_c = 2'd1;
                        state_d  = S_WB;
                    end
                    OPC_OPIMM: begin
                        alu_b_sel_c = 1'b1;
                        alu_op_c    = 2'd1;
                        state_d     = S_WB;
                    end
                    OPC_LUI: begin
                        alu_a_sel_c = 2'd2;
                        alu_b_sel_c = 1'b1;
                        state_d     = S_WB;
                    end
                    OPC_AUIPC: begin
                        alu_a_sel_c = 2'd1;
                        alu_b_sel_c = 1'b1;
                        state_d     = S_WB;
                    end
                    OPC_LOAD, OPC_STORE: begin
                        alu_b_sel_c = 1'b1;
                        state_d     = S_MEM;
                    end
                    OPC_BRANCH: begin
                        alu_a_sel_c  = 2'd1;
                        alu_b_sel_c  = 1'b1;
                        alu_op_c     = 2'd2;
                        pc_we_c      = br_taken;
                        pc_src_c     = 1'b1;
                        instr_done_c = 1'b1;
                        state_d      = S_FETCH;
                    end
                    OPC_JAL, OPC_JALR: begin
                        // Link and jump share the cycle; the register file still
                        // sees the pre-update PC as the link value.
                        alu_a_sel_c  = (opcode == OPC_JAL) ? 2'd1 : 2'd0;
                        alu_b_sel_c  = 1'b1;
                        pc_we_c      = 1'b1;
                        pc_src_c     = 1'b1;
                        rf_we_c      = 1'b1;
                        wb_sel_c     = 2'd2;
                        instr_done_c = 1'b1;
                        state_d      = S_FETCH;
                    end
                    OPC_SYSTEM: state_d = S_HALT;
                    // FENCE and, without the trap feature, illegal opcodes retire as NOPs.
                    default: begin
                        instr_done_c = 1'b1;
                        state_d      = S_FETCH;
                    end
                endcase
            end
            S_MEM: begin
                mem_req_c      = 1'b1;
                mem_addr_sel_c = 1'b1;
                mem_we_c       = opcode == OPC_STORE;
                if (mem_ready) begin
                    instr_done_c = opcode == OPC_STORE;
                    state_d      = (opcode == OPC_STORE) ? S_FETCH : S_WB;
                end
            end
            S_WB: begin
                rf_we_c      = 1'b1;
                wb_sel_c     = (opcode == OPC_LOAD) ? 2'd1 : 2'd0;
                instr_done_c = 1'b1;
                state_d      = S_FETCH;
            end
            S_HALT: halt_c = 1'b1;
            default: state_d = S_FETCH;
        endcase
        wait_c  = mem_req_c && !mem_ready;
        wd_d    = wait_c ? wd_q + 1'b1 : '0;
        fbusy_d = (state_q == S_FETCH) && wait_c;
        if (MEM_TIMEOUT != 0 && wait_c && wd_q == WD_LIM) state_d = S_HALT;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_FETCH;
            wd_q    <= '0;
            fbusy_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
            fbusy_q <= fbusy_d;
        end
    end

    // Outputs are held low during reset so a pending request is dropped immediately.
    assign pc_we        = !RST && pc_we_c;
    assign pc_src       = !RST && pc_src_c;
    assign ir_we        = !RST && ir_we_c;
    assign rf_we        = !RST && rf_we_c;
    assign wb_sel       = RST ? 2'd0 : wb_sel_c;
    assign alu_a_sel    = RST ? 2'd0 : alu_a_sel_c;
    assign alu_b_sel    = !RST && alu_b_sel_c;
    assign alu_op       = RST ? 2'd0 : alu_op_c;
    assign mem_req      = !RST && mem_req_c;
    assign mem_we       = !RST && mem_we_c;
    assign mem_addr_sel = !RST && mem_addr_sel_c;
    assign instr_done   = !RST && instr_done_c;
    assign halt         = !RST && halt_c;
    assign state_dbg    = RST ? S_FETCH : state_q;
endmodule

// File: tb/tb_riscv_mc_ctrl.sv
// tb_riscv_mc_ctrl: table-driven scoreboard bench for the multi-cycle control sequencer
module tb_riscv_mc_ctrl;
    localparam logic [6:0] ADDI   = 7'b0010011;
    localparam logic [6:0] OPR    = 7'b0110011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] FENCE  = 7'b0001111;
    localparam logic [6:0] SYSTEM = 7'b1110011;
    localparam logic [6:0] ILL    = 7'b1111111;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       run = 1'b1;
    logic [6:0] opcode = '0;
    logic       br_taken = 1'b0;
    logic       mem_ready = 1'b1;
    logic       pc_we, pc_src, ir_we, rf_we, alu_b_sel, mem_req, mem_we, mem_addr_sel;
    logic       instr_done, halt;
    logic [1:0] wb_sel, alu_a_sel, alu_op;
    logic [2:0] state_dbg;
    logic [18:0] act;
    logic       halt_seen = 1'b0;

    typedef struct {
        logic        rst;
        logic        run;
        logic [6:0]  opc;
        logic        br;
        logic        rdy;
        logic [18:0] exp;
        string       name;
    } vec_t;

    typedef struct {
        logic [18:0] exp;
        string       name;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];
    int   tests = 0;
    int   fails = 0;

    riscv_mc_ctrl #(.MEM_TIMEOUT(4)) dut (
        .CLK(CLK), .RST(RST), .run(run), .opcode(opcode), .br_taken(br_taken),
        .mem_ready(mem_ready), .pc_we(pc_we), .pc_src(pc_src), .ir_we(ir_we),
        .rf_we(rf_we), .wb_sel(wb_sel), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
        .alu_op(alu_op), .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
        .instr_done(instr_done), .halt(halt), .state_dbg(state_dbg)
    );

    always #5 CLK = ~CLK;

    assign act = {pc_we, pc_src, ir_we, rf_we, wb_sel, alu_a_sel, alu_b_sel, alu_op,
                  mem_req, mem_we, mem_addr_sel, instr_done, halt, state_dbg};

    function automatic logic [18:0] e(input logic [2:0] st, input logic pw, ps, iw, rw,
                                      input logic [1:0] wb, a, input logic b,
                                      input logic [1:0] op, input logic rq, we, as, dn, hl);
        return {pw, ps, iw, rw, wb, a, b, op, rq, we, as, dn, hl, st};
    endfunction

    task automatic add(input logic r, ru, input logic [6:0] o, input logic b, rd,
                       input logic [18:0] x, input string n);
        vec_t v;
        v.rst = r; v.run = ru; v.opc = o; v.br = b; v.rdy = rd; v.exp = x; v.name = n;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic r, ru, input logic [6:0] o, input logic b, rd,
                         input logic [18:0] x, input string n);
        sb_t s;
        @(posedge CLK);
        #1;
        RST = r; run = ru; opcode = o; br_taken = b; mem_ready = rd;
        s.exp = x; s.name = n;
        sb.push_back(s);
    endtask

    always @(negedge CLK) begin
        if (sb.size() > 0) begin
            sb_t s;
            s = sb.pop_front();
            tests++;
            if (act !== s.exp) begin
                fails++;
                $display("FAIL %s: got %b expected %b (pw ps iw rw wb a b op rq we as dn hl st)",
                         s.name, act, s.exp);
            end
        end
    end

    always @(negedge CLK) begin
        if (RST) begin
            tests++;
            if (act !== '0) begin
                fails++;
                $display("FAIL reset_state: got %b expected all zero", act);
            end
        end
    end

    always @(posedge CLK) halt_seen <= RST ? 1'b0 : (halt_seen || halt);

    always @(negedge CLK) begin
        if (halt_seen && !RST) begin
            tests++;
            if (halt !== 1'b1 || state_dbg !== 3'd5) begin
                fails++;
                $display("FAIL halt_sticky: halt=%b state=%0d after expired wait", halt, state_dbg);
            end
        end
    end

    initial begin
        logic [18:0] idle, f_ok, f_w, dec, hlt, x_ldst, m_wait, wb_alu;
        idle   = e(0, 0,0,0,0, 0,0,0,0, 0,0,0,0,0);
        f_ok   = e(0, 1,0,1,0, 0,0,0,0, 1,0,0,0,0);
        f_w    = e(0, 0,0,0,0, 0,0,0,0, 1,0,0,0,0);
        dec    = e(1, 0,0,0,0, 0,0,0,0, 0,0,0,0,0);
        hlt    = e(5, 0,0,0,0, 0,0,0,0, 0,0,0,0,1);
        x_ldst = e(2, 0,0,0,0, 0,0,1,0, 0,0,0,0,0);
        m_wait = e(3, 0,0,0,0, 0,0,0,0, 1,0,1,0,0);
        wb_alu = e(4, 0,0,0,1, 0,0,0,0, 0,0,0,1,0);

        add(1,1,ADDI,0,1, idle, "rst_c0");
        add(1,1,ADDI,0,1, idle, "rst_c1");
        add(0,0,ADDI,0,1, idle, "run0_a");
        add(0,0,ADDI,0,1, idle, "run0_b");
        add(0,0,ADDI,0,1, idle, "run0_c");
        add(0,1,ADDI,0,1, f_ok, "addi_fetch");
        add(0,1,ADDI,0,1, dec, "addi_dec");
        add(0,1,ADDI,0,1, e(2, 0,0,0,0, 0,0,1,1, 0,0,0,0,0), "addi_exec");
        add(0,1,ADDI,0,1, wb_alu, "addi_wb");
        add(0,1,OPR,0,0, f_w, "op_fetch_wait");
        add(0,0,OPR,0,0, f_w, "op_fetch_hold");
        add(0,0,OPR,0,1, f_ok, "op_fetch");
        add(0,0,OPR,0,1, dec, "op_dec");
        add(0,0,OPR,0,1, e(2, 0,0,0,0, 0,0,0,1, 0,0,0,0,0), "op_exec");
        add(0,0,OPR,0,1, wb_alu, "op_wb");
        add(0,0,OPR,0,1, idle, "op_idle");
        add(0,1,LOAD,0,1, f_ok, "ld_fetch");
        add(0,1,LOAD,0,1, dec, "ld_dec");
        add(0,1,LOAD,0,1, x_ldst, "ld_exec");
        add(0,1,LOAD,0,0, m_wait, "ld_mem_w1");
        add(0,1,LOAD,0,0, m_wait, "ld_mem_w2");
        add(0,1,LOAD,0,0, m_wait, "ld_mem_w3");
        add(0,1,LOAD,0,1, m_wait, "ld_mem_done");
        add(0,1,LOAD,0,1, e(4, 0,0,0,1, 1,0,0,0, 0,0,0,1,0), "ld_wb");
        add(0,1,STORE,0,1, f_ok, "st_fetch");
        add(0,1,STORE,0,1, dec, "st_dec");
        add(0,1,STORE,0,1, x_ldst, "st_exec");
        add(0,1,STORE,0,1, e(3, 0,0,0,0, 0,0,0,0, 1,1,1,1,0), "st_mem");
        add(0,1,BRANCH,0,1, f_ok, "bnt_fetch");
        add(0,1,BRANCH,0,1, dec, "bnt_dec");
        add(0,1,BRANCH,0,1, e(2, 0,1,0,0, 0,1,1,2, 0,0,0,1,0), "bnt_exec");
        add(0,1,BRANCH,1,1, f_ok, "bt_fetch");
        add(0,1,BRANCH,1,1, dec, "bt_dec");
        add(0,1,BRANCH,1,1, e(2, 1,1,0,0, 0,1,1,2, 0,0,0,1,0), "bt_exec");
        add(0,1,JAL,0,1, f_ok, "jal_fetch");
        add(0,1,JAL,0,1, dec, "jal_dec");
        add(0,1,JAL,0,1, e(2, 1,1,0,1, 2,1,1,0, 0,0,0,1,0), "jal_exec");
        add(0,1,JALR,0,1, f_ok, "jalr_fetch");
        add(0,1,JALR,0,1, dec, "jalr_dec");
        add(0,1,JALR,0,1, e(2, 1,1,0,1, 2,0,1,0, 0,0,0,1,0), "jalr_exec");
        add(0,1,LUI,0,1, f_ok, "lui_fetch");
        add(0,1,LUI,0,1, dec, "lui_dec");
        add(0,1,LUI,0,1, e(2, 0,0,0,0, 0,2,1,0, 0,0,0,0,0), "lui_exec");
        add(0,1,LUI,0,1, wb_alu, "lui_wb");
        add(0,1,AUIPC,0,1, f_ok, "auipc_fetch");
        add(0,1,AUIPC,0,1, dec, "auipc_dec");
        add(0,1,AUIPC,0,1, e(2, 0,0,0,0, 0,1,1,0, 0,0,0,0,0), "auipc_exec");
        add(0,1,AUIPC,0,1, wb_alu, "auipc_wb");
        add(0,1,FENCE,0,1, f_ok, "fence_fetch");
        add(0,1,FENCE,0,1, dec, "fence_dec");
        add(0,1,FENCE,0,1, e(2, 0,0,0,0, 0,0,0,0, 0,0,0,1,0), "fence_exec");
        add(0,1,LOAD,0,1, f_ok, "abort_fetch");
        add(0,1,LOAD,0,1, dec, "abort_dec");
        add(0,1,LOAD,0,1, x_ldst, "abort_exec");
        add(0,1,LOAD,0,0, m_wait, "abort_mem");
        add(1,1,LOAD,0,0, idle, "abort_rst");
        add(0,0,LOAD,0,0, idle, "abort_after");
        add(0,0,LOAD,0,1, idle, "abort_idle");
        add(0,1,SYSTEM,0,1, f_ok, "sys_fetch");
        add(0,1,SYSTEM,0,1, dec, "sys_dec");
        add(0,1,SYSTEM,0,1, e(2, 0,0,0,0, 0,0,0,0, 0,0,0,0,0), "sys_exec");
        add(0,1,SYSTEM,0,1, hlt, "sys_halt0");
        add(0,1,ADDI,0,1, hlt, "sys_halt1");
        add(1,1,ADDI,0,1, idle, "sys_rst");
        add(0,1,ILL,0,1, f_ok, "ill_fetch");
        add(0,1,ILL,0,1, dec, "ill_dec");
`ifdef RISCV_MC_CTRL_ILLEGAL_TRAP_EN
        add(0,1,ILL,0,1, hlt, "ill_halt0");
        add(0,0,ILL,0,1, hlt, "ill_halt1");
`else
        add(0,1,ILL,0,1, e(2, 0,0,0,0, 0,0,0,0, 0,0,0,1,0), "ill_nop_exec");
        add(0,0,ILL,0,1, idle, "ill_nop_fetch");
`endif
        add(1,1,ILL,0,1, idle, "ill_rst");
        add(0,1,ADDI,0,0, f_w, "wd_w1");
        add(0,1,ADDI,0,0, f_w, "wd_w2");
        add(0,1,ADDI,0,0, f_w, "wd_w3");
        add(0,1,ADDI,0,0, f_w, "wd_w4");
        add(0,1,ADDI,0,0, hlt, "wd_halt0");
        add(0,1,ADDI,0,1, hlt, "wd_halt1");
        add(0,0,ADDI,0,1, hlt, "wd_halt2");
        add(1,1,ADDI,0,1, idle, "wd_rst");

        for (int i = 0; i < vecs.size(); i++)
            drive(vecs[i].rst, vecs[i].run, vecs[i].opc, vecs[i].br, vecs[i].rdy,
                  vecs[i].exp, vecs[i].name);

        for (int i = 0; i < 12; i++)
            drive(0, 0, ADDI, 0, 1, idle, "idle_run0");

        @(posedge CLK);
        #1;
        @(negedge CLK);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/riscv_mc_ctrl.md
Name: riscv_mc_ctrl

Overview:
- Control sequencer for the multi-cycle RV32I core that sits under the top level and drives the display.
- Walks each instruction through fetch, decode, execute, memory and writeback states.
- Drives every enable and mux select of the PC, IR, register file, ALU and memory port.
- Performs the valid/ready handshake with the shared instruction/data memory port, with a watchdog on memory stalls.

Parameters:
MEM_TIMEOUT, 255, max cycles a memory request may wait for mem_ready before entering HALT; 0 disables the watchdog.

Ports:
CLK  input  1  system clock, rising-edge.
RST  input  1  synchronous reset, active-high.
run  input  1  1 = core may start a new instruction fetch.
opcode  input  7  IR[6:0], valid from DECODE onward.
br_taken  input  1  datapath branch comparison result, valid in EXEC.
mem_ready  input  1  memory port completes the current request this cycle.
pc_we  output  1  PC register write.
pc_src  output  1  0 = PC+4, 1 = ALU result.
ir_we  output  1  IR and OLDPC capture (OLDPC = PC of the fetched instruction).
rf_we  output  1  register file write.
wb_sel  output  2  0 = ALU, 1 = memory read data, 2 = PC (link value).
alu_a_sel  output  2  0 = rs1, 1 = OLDPC, 2 = zero.
alu_b_sel  output  1  0 = rs2, 1 = immediate.
alu_op  output  2  0 = add, 1 = funct-decoded, 2 = branch compare.
mem_req  output  1  memory request valid.
mem_we  output  1  store (qualifies mem_req).
mem_addr_sel  output  1  0 = PC, 1 = ALU result.
instr_done  output  1  one-cycle pulse when an instruction retires.
halt  output  1  core halted; sticky until RST.
state_dbg  output  3  current state encoding.

Behaviour:
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5. Reset: state FETCH, watchdog counter 0.
- All outputs are combinational from the state register and inputs. They are forced to 0 while RST is high.
- Unlisted outputs are 0 in each state.
- FETCH:
  - If run=0: stay in FETCH, all outputs 0.
  - If run=1: mem_req=1, mem_addr_sel=0.
  - On mem_ready=1: ir_we=1, pc_we=1, pc_src=0, then go to DECODE.
  - On mem_ready=0: stay in FETCH; mem_req stays held.
- DECODE: no enables asserted; next state is EXEC. Illegal opcode handling is set by the optional feature.
- EXEC, by opcode class:
  - OP (0110011): a=rs1, b=rs2, alu_op=1, then WB.
  - OP-IMM (0010011): a=rs1, b=imm, alu_op=1, then WB.
  - LUI (0110111): a=zero, b=imm, alu_op=0, then WB.
  - AUIPC (0010111): a=OLDPC, b=imm, alu_op=0, then WB.
  - LOAD (0000011) / STORE (0100011): a=rs1, b=imm, alu_op=0, then MEM.
  - BRANCH (1100011): a=OLDPC, b=imm, alu_op=2. pc_we=br_taken, pc_src=1. instr_done=1, then FETCH.
  - JAL (1101111): a=OLDPC, b=imm, alu_op=0, pc_we=1, pc_src=1, rf_we=1, wb_sel=2, instr_done=1, then FETCH.
  - JALR (1100111): as JAL, except a=rs1. The datapath clears bit 0 of the target.
  - FENCE (0001111): instr_done=1, then FETCH.
  - SYSTEM (1110011): go to HALT. instr_done is not asserted.
- JAL/JALR link write and PC write occur in the same cycle. The register file captures the pre-update PC (old PC+4).
- MEM:
  - mem_req=1, mem_addr_sel=1, mem_we=1 for STORE.
  - On mem_ready=1: STORE asserts instr_done=1 and goes to FETCH; LOAD goes to WB.
  - On mem_ready=0: stay in MEM.
- WB: rf_we=1; wb_sel=1 for LOAD, otherwise 0. instr_done=1, then FETCH.
- HALT: halt=1, all other outputs 0. Exit only by RST.
- Watchdog:
  - Counts cycles while mem_req=1 && mem_ready=0. Clears on handshake completion or on leaving FETCH/MEM.
  - If MEM_TIMEOUT≠0 and the count reaches MEM_TIMEOUT with mem_ready still 0, go to HALT on the next edge.
  - mem_ready=1 in the same cycle as the count reaching the limit completes the handshake; no halt.
- run dropping to 0 mid-instruction has no effect. It is checked only when in FETCH before the handshake starts. Once mem_req is high in FETCH, the request is held regardless of run.
- RST mid-operation aborts any pending request: mem_req deasserts in the reset cycle and state returns to FETCH.
- Cycles per instruction with zero-wait memory: branch/JAL/JALR/FENCE 3, OP/OP-IMM/LUI/AUIPC/STORE 4, LOAD 5.

Optional Feature:
RISCV_MC_CTRL_ILLEGAL_TRAP_EN
- Defined: an opcode outside the listed set in DECODE goes to HALT.
- Undefined: an illegal opcode is a NOP. DECODE → EXEC, which asserts instr_done=1 and returns to FETCH with no other enables; 3 cycles.

Test Plan:
- Reset/run:
  - RST high 2 cycles with run=1 and mem_ready=1 → all outputs 0, state_dbg=0.
  - After release with run=0 → mem_req stays 0 indefinitely.
- ADDI (0010011), mem_ready tied 1 → state_dbg sequence 0,1,2,4. rf_we=1 only in WB; instr_done pulse on cycle 4; pc_we only in cycle 1.
- LOAD with mem_ready low for 3 cycles in MEM → mem_req held for 4 cycles with mem_addr_sel=1, then WB with wb_sel=1; total 8 cycles.
- BRANCH with br_taken=0 then 1 → pc_we=0 / 1 in EXEC with pc_src=1; each instruction retires in 3 cycles.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH → HALT after the 4th waiting cycle; halt=1 persists until RST.
- Opcode 1111111 → HALT when macro defined; instr_done after 3 cycles and return to FETCH when undefined.
